da_filter: RTL and testbench
============================

// Module: da_filter
// PURPOSE
//  Parametrised, registered Ethernet RX destination-address filter after the reconciliation sublayer.
//  Compares the first DA block (PLS_DATA_IND[47:0] on FRAME_START) against NUM_UCAST programmable
//  unicast entries, broadcast, IPv4 multicast (01-00-5E-0) and IPv6 multicast (33-33).
//  Holds the accept verdict for the whole frame so downstream RX logic gates storage on it.
// PARAMETERS
//  DATA_W     64  PLS data width; DA always in bits [47:0]
//  NUM_UCAST  4   unicast table entries (1..16)
//  IDX_W      4   width of table index ports (>= clog2(NUM_UCAST))
//  CNT_W      32  statistics counter width
// PORTS
//  CLK           in   1         rising-edge clock
//  RST_N         in   1         synchronous reset, active-low
//  FRAME_START   in   1         1-cycle strobe; DA block valid on PLS_DATA_IND this cycle
//  FRAME_END     in   1         1-cycle strobe; last data block of frame
//  PLS_DATA_IND  in   DATA_W    RX data from RS, one cycle delayed
//  PROMISC       in   1         accept every frame
//  BCAST_EN      in   1         accept FF-FF-FF-FF-FF-FF
//  MCAST_EN      in   1         accept IPv4/IPv6 multicast prefixes
//  CFG_WR        in   1         table write strobe
//  CFG_IDX       in   IDX_W     entry index for write
//  CFG_ADDR      in   48        unicast address written
//  CFG_ENTRY_EN  in   1         entry enable written with address
//  DA_VALID      out  1         frame accepted; high from decision cycle through FRAME_END cycle
//  DA_DONE       out  1         1-cycle strobe: verdict available (accept or drop)
//  DA_CLASS      out  2         0 ucast, 1 bcast, 2 mcast, 3 promisc-only/none
//  DA_MATCH_IDX  out  IDX_W     matching table entry (valid when DA_CLASS==0 and DA_VALID)
//  ACCEPT_CNT    out  CNT_W     accepted-frame count (stats build only)
//  DROP_CNT      out  CNT_W     dropped-frame count (stats build only)
// BEHAVIOUR
//  - Reset (RST_N low at edge): all outputs 0, FSM IDLE; table entry 0 = 48'h00_00_00_11_11_11
//    enabled, other entries 0 and disabled. Reset mid-frame discards the frame, no count.
//  - FSM: IDLE -> (FRAME_START) DECIDE -> accept ? IN_FRAME : IDLE.
//    IN_FRAME -> IDLE on FRAME_END. DECIDE lasts exactly one cycle.
//  - Latency: DA_DONE, DA_VALID, DA_CLASS, DA_MATCH_IDX registered 1 cycle after FRAME_START.
//  - Match rules on captured DA, priority: enabled table entry (lowest index wins) > broadcast
//    (BCAST_EN) > multicast (MCAST_EN: [47:23]==25'b00000001_00000000_01011110_0 or
//    [47:32]==16'h3333) > PROMISC (class 3). No hit and PROMISC=0 -> drop, DA_VALID stays 0.
//  - DA_VALID falls the cycle after FRAME_END. FRAME_END during DECIDE (1-block frame):
//    DA_VALID pulses for that decision cycle only, FSM returns to IDLE.
//  - FRAME_START in IN_FRAME: previous frame closed without count change, new decision
//    follows normally (FRAME_START wins over FRAME_END when simultaneous).
//  - FRAME_END in IDLE ignored. Mode inputs sampled only on the FRAME_START cycle.
//  - CFG_WR: table updated at clock edge; write on the FRAME_START cycle does not affect that
//    frame's decision (old entry used). CFG_IDX >= NUM_UCAST ignored.
//  - DA_CLASS/DA_MATCH_IDX hold until next decision; reset to 0 on drop.
// CONFIGURATION
//  - DA_FILTER_STATS_EN defined: ACCEPT_CNT/DROP_CNT increment on DA_DONE by verdict,
//    saturate at all-ones, cleared only by reset.
//  - Not defined: counter logic omitted, ACCEPT_CNT/DROP_CNT tied to 0.
// TESTING
//  - Reset, DA=48'h000000111111 on FRAME_START -> next cycle DA_DONE=1, DA_VALID=1, class 0, idx 0.
//  - Write idx 2 = 48'h0A0B0C0D0E0F enabled; send that DA -> DA_VALID=1, DA_MATCH_IDX=2;
//    FRAME_END 5 cycles later -> DA_VALID low next cycle.
//  - DA=48'h01005E7F0001, MCAST_EN=0 -> drop; MCAST_EN=1 -> class 2; 48'h3333_00000001 -> class 2.
//  - DA=48'hFFFFFFFFFFFF, BCAST_EN=0, PROMISC=1 -> accepted class 3; BCAST_EN=1 -> class 1.
//  - FRAME_START while IN_FRAME and CFG_WR same cycle as FRAME_START -> new verdict uses old table.
//  - Stats build: 3 accepts, 2 drops -> ACCEPT_CNT=3, DROP_CNT=2; RST_N low mid-frame -> both 0.

Source files
------------

// File: rtl/da_filter.sv
`default_nettype none
// ============================================================================
//  Module      : da_filter
//  Description : Registered Ethernet RX destination-address filter. Captures
//                the DA from the first PLS block of a frame, matches it
//                against a programmable unicast table, broadcast and
//                IPv4/IPv6 multicast prefixes, and holds the accept verdict
//                for the duration of the frame.
//  Options     : DA_FILTER_STATS_EN - enables saturating accept/drop counters
//                (ACCEPT_CNT/DROP_CNT tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module da_filter #(
  parameter int DATA_W    = 64,
  parameter int NUM_UCAST = 4,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FRAME_START,
  input  logic              FRAME_END,
  input  logic [DATA_W-1:0] PLS_DATA_IND,
  input  logic              PROMISC,
  input  logic              BCAST_EN,
  input  logic              MCAST_EN,
  input  logic              CFG_WR,
  input  logic [IDX_W-1:0]  CFG_IDX,
  input  logic [47:0]       CFG_ADDR,
  input  logic              CFG_ENTRY_EN,
  output logic              DA_VALID,
  output logic              DA_DONE,
  output logic [1:0]        DA_CLASS,
  output logic [IDX_W-1:0]  DA_MATCH_IDX,
  output logic [CNT_W-1:0]  ACCEPT_CNT,
  output logic [CNT_W-1:0]  DROP_CNT
);

  localparam logic [47:0] RST_ENTRY0   = 48'h00_00_00_11_11_11;
  localparam logic [24:0] MCAST4_PFX   = 25'b00000001_00000000_01011110_0;
  localparam logic [15:0] MCAST6_PFX   = 16'h3333;
  localparam logic [1:0]  CLASS_UCAST  = 2'd0;
  localparam logic [1:0]  CLASS_BCAST  = 2'd1;
  localparam logic [1:0]  CLASS_MCAST  = 2'd2;
  localparam logic [1:0]  CLASS_PROMS  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DECIDE   = 2'd1,
    S_IN_FRAME = 2'd2
  } state_t;

  state_t             state_q;
  logic [47:0]        addr_q [NUM_UCAST];
  logic               en_q   [NUM_UCAST];
  logic               valid_q;
  logic               done_q;
  logic [1:0]         class_q;
  logic [IDX_W-1:0]   idx_q;

  logic [47:0]        da_d;
  logic               ucast_hit_d;
  logic [IDX_W-1:0]   ucast_idx_d;
  logic               bcast_hit_d;
  logic               mcast_hit_d;
  logic               accept_d;
  logic [1:0]         class_d;
  logic [IDX_W-1:0]   idx_d;

  assign da_d = PLS_DATA_IND[47:0];

  // Upper PLS bits carry payload only; they never take part in the match.
  generate
    if (DATA_W > 48) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^PLS_DATA_IND[DATA_W-1:48];
    end
  endgenerate

  // Unicast table: writes land at the clock edge, out-of-range indices drop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_UCAST; i++) begin
        addr_q[i] <= (i == 0) ? RST_ENTRY0 : 48'h0;
        en_q[i]   <= (i == 0);
      end
    end else if (CFG_WR) begin
      for (int i = 0; i < NUM_UCAST; i++) begin
        if (CFG_IDX == IDX_W'(i)) begin
          addr_q[i] <= CFG_ADDR;
          en_q[i]   <= CFG_ENTRY_EN;
        end
      end
    end
  end

  // Match the live DA against the current (pre-write) table and prefixes.
  always_comb begin
    ucast_hit_d = 1'b0;
    ucast_idx_d = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = NUM_UCAST - 1; i >= 0; i--) begin
      if (en_q[i] && (addr_q[i] == da_d)) begin
        ucast_hit_d = 1'b1;
        ucast_idx_d = IDX_W'(i);
      end
    end
    bcast_hit_d = BCAST_EN && (&da_d);
    mcast_hit_d = MCAST_EN && ((da_d[47:23] == MCAST4_PFX) || (da_d[47:32] == MCAST6_PFX));

    accept_d = 1'b1;
    class_d  = CLASS_UCAST;
    idx_d    = '0;
    if (ucast_hit_d) begin
      idx_d = ucast_idx_d;
    end else if (bcast_hit_d) begin
      class_d = CLASS_BCAST;
    end else if (mcast_hit_d) begin
      class_d = CLASS_MCAST;
    end else if (PROMISC) begin
      class_d = CLASS_PROMS;
    end else begin
      accept_d = 1'b0;
    end
  end

  // Frame FSM with registered verdict outputs; FRAME_START always opens a new decision.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= 2'd0;
      idx_q   <= '0;
    end else begin
      done_q <= FRAME_START;
      if (FRAME_START) begin
        state_q <= S_DECIDE;
        valid_q <= accept_d;
        class_q <= accept_d ? class_d : 2'd0;
        idx_q   <= accept_d ? idx_d   : '0;
      end else begin
        case (state_q)
          S_DECIDE: begin
            // A dropped frame or a one-block frame goes straight back to idle.
            if (valid_q && !FRAME_END) begin
              state_q <= S_IN_FRAME;
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end
          S_IN_FRAME: begin
            if (FRAME_END) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DA_VALID     = valid_q;
  assign DA_DONE      = done_q;
  assign DA_CLASS     = class_q;
  assign DA_MATCH_IDX = idx_q;

`ifdef DA_FILTER_STATS_EN
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  // Saturating verdict counters, advanced once per decision.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (done_q) begin
      if (valid_q) begin
        if (~&acc_cnt_q) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end else begin
        if (~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ACCEPT_CNT = acc_cnt_q;
  assign DROP_CNT   = drop_cnt_q;
`else
  assign ACCEPT_CNT = '0;
  assign DROP_CNT   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_da_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_da_filter
//  Description : Directed self-checking bench for da_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_da_filter;

  localparam int DATA_W    = 64;
  localparam int NUM_UCAST = 4;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 32;

  logic              CLK;
  logic              RST_N;
  logic              FRAME_START;
  logic              FRAME_END;
  logic [DATA_W-1:0] PLS_DATA_IND;
  logic              PROMISC;
  logic              BCAST_EN;
  logic              MCAST_EN;
  logic              CFG_WR;
  logic [IDX_W-1:0]  CFG_IDX;
  logic [47:0]       CFG_ADDR;
  logic              CFG_ENTRY_EN;
  logic              DA_VALID;
  logic              DA_DONE;
  logic [1:0]        DA_CLASS;
  logic [IDX_W-1:0]  DA_MATCH_IDX;
  logic [CNT_W-1:0]  ACCEPT_CNT;
  logic [CNT_W-1:0]  DROP_CNT;

  int errors = 0;
  int checks = 0;

  da_filter #(
    .DATA_W(DATA_W), .NUM_UCAST(NUM_UCAST), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME_START(FRAME_START), .FRAME_END(FRAME_END),
    .PLS_DATA_IND(PLS_DATA_IND), .PROMISC(PROMISC), .BCAST_EN(BCAST_EN),
    .MCAST_EN(MCAST_EN), .CFG_WR(CFG_WR), .CFG_IDX(CFG_IDX), .CFG_ADDR(CFG_ADDR),
    .CFG_ENTRY_EN(CFG_ENTRY_EN), .DA_VALID(DA_VALID), .DA_DONE(DA_DONE),
    .DA_CLASS(DA_CLASS), .DA_MATCH_IDX(DA_MATCH_IDX), .ACCEPT_CNT(ACCEPT_CNT),
    .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Present one DA block with FRAME_START; outputs after return are the decision cycle.
  task automatic send(input logic [47:0] da, input logic p, input logic b, input logic m);
    FRAME_START  = 1'b1;
    PLS_DATA_IND = {16'hDEAD, da};
    PROMISC      = p;
    BCAST_EN     = b;
    MCAST_EN     = m;
    cyc();
    FRAME_START  = 1'b0;
    CFG_WR       = 1'b0;
    PLS_DATA_IND = {$urandom, $urandom};
    PROMISC      = 1'b0;
    BCAST_EN     = 1'b0;
    MCAST_EN     = 1'b0;
  endtask

  task automatic end_frame();
    FRAME_END = 1'b1;
    cyc();
    FRAME_END = 1'b0;
  endtask

  task automatic cfg(input logic [IDX_W-1:0] idx, input logic [47:0] addr, input logic en);
    CFG_WR = 1'b1; CFG_IDX = idx; CFG_ADDR = addr; CFG_ENTRY_EN = en;
    cyc();
    CFG_WR = 1'b0;
  endtask

  task automatic verdict(input string tag, input logic v, input logic [1:0] c, input logic [IDX_W-1:0] i);
    chk({tag, "_done"},  64'(DA_DONE),      64'd1);
    chk({tag, "_valid"}, 64'(DA_VALID),     64'(v));
    chk({tag, "_class"}, 64'(DA_CLASS),     64'(c));
    chk({tag, "_idx"},   64'(DA_MATCH_IDX), 64'(i));
  endtask

  initial begin
    RST_N = 1'b0; FRAME_START = 1'b0; FRAME_END = 1'b0; PLS_DATA_IND = '0;
    PROMISC = 1'b0; BCAST_EN = 1'b0; MCAST_EN = 1'b0;
    CFG_WR = 1'b0; CFG_IDX = '0; CFG_ADDR = '0; CFG_ENTRY_EN = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 64'(DA_VALID), 64'd0);
    chk("rst_done",  64'(DA_DONE),  64'd0);
    chk("rst_class", 64'(DA_CLASS), 64'd0);
    chk("rst_idx",   64'(DA_MATCH_IDX), 64'd0);
    chk("rst_acc",   64'(ACCEPT_CNT), 64'd0);
    chk("rst_drop",  64'(DROP_CNT), 64'd0);
    RST_N = 1'b1;
    cyc();

    // A: reset table entry 0
    send(48'h000000111111, 0, 0, 0);
    verdict("A", 1, 2'd0, 4'd0);
    cyc();
    chk("A_hold_done",  64'(DA_DONE),  64'd0);
    chk("A_hold_valid", 64'(DA_VALID), 64'd1);
    end_frame();
    chk("A_end_valid", 64'(DA_VALID), 64'd0);
    end_frame();                              // FRAME_END in IDLE ignored
    chk("idle_fe_valid", 64'(DA_VALID), 64'd0);

    // B: programmed entry 2, FRAME_END five cycles after FRAME_START
    cfg(4'd2, 48'h0A0B0C0D0E0F, 1'b1);
    send(48'h0A0B0C0D0E0F, 0, 0, 0);
    verdict("B", 1, 2'd0, 4'd2);
    cyc(); cyc(); cyc();
    chk("B_mid_valid", 64'(DA_VALID), 64'd1);
    end_frame();
    chk("B_end_valid", 64'(DA_VALID), 64'd0);
    chk("B_end_class", 64'(DA_CLASS), 64'd0);

    // C/D/E: multicast
    send(48'h01005E7F0001, 0, 0, 0);
    verdict("C", 0, 2'd0, 4'd0);
    cyc();
    chk("C_after_valid", 64'(DA_VALID), 64'd0);
    send(48'h01005E7F0001, 0, 0, 1);
    verdict("D", 1, 2'd2, 4'd0);
    end_frame();                              // one-block frame
    chk("D_1blk_valid", 64'(DA_VALID), 64'd0);
    send(48'h333300000001, 0, 0, 1);
    verdict("E", 1, 2'd2, 4'd0);
    end_frame();
    chk("E_1blk_valid", 64'(DA_VALID), 64'd0);

    // F/G: broadcast vs promiscuous
    send(48'hFFFFFFFFFFFF, 1, 0, 0);
    verdict("F", 1, 2'd3, 4'd0);
    end_frame();
    send(48'hFFFFFFFFFFFF, 0, 1, 0);
    verdict("G", 1, 2'd1, 4'd0);
    cyc();
    chk("G_inframe_valid", 64'(DA_VALID), 64'd1);

    // H: FRAME_START while IN_FRAME with same-cycle table write to entry 0
    CFG_WR = 1'b1; CFG_IDX = 4'd0; CFG_ADDR = 48'h123456789ABC; CFG_ENTRY_EN = 1'b1;
    send(48'h000000111111, 0, 0, 0);
    verdict("H", 1, 2'd0, 4'd0);
    end_frame();
    // I: entry 0 now replaced
    send(48'h000000111111, 0, 0, 0);
    verdict("I", 0, 2'd0, 4'd0);
    // J: out-of-range index write ignored
    cfg(4'd4, 48'h000000000AAA, 1'b1);
    send(48'h000000000AAA, 0, 0, 0);
    verdict("J", 0, 2'd0, 4'd0);
    // K: lowest matching index wins
    cfg(4'd1, 48'h0A0B0C0D0E0F, 1'b1);
    send(48'h0A0B0C0D0E0F, 0, 0, 0);
    verdict("K", 1, 2'd0, 4'd1);
    end_frame();
    // L: unicast entry outranks broadcast
    cfg(4'd3, 48'hFFFFFFFFFFFF, 1'b1);
    send(48'hFFFFFFFFFFFF, 1, 1, 1);
    verdict("L", 1, 2'd0, 4'd3);
    end_frame();
    cyc();
`ifdef DA_FILTER_STATS_EN
    chk("stat_acc",  64'(ACCEPT_CNT), 64'd9);
    chk("stat_drop", 64'(DROP_CNT),   64'd3);
`else
    chk("stat_acc",  64'(ACCEPT_CNT), 64'd0);
    chk("stat_drop", 64'(DROP_CNT),   64'd0);
`endif

    // M: reset mid-frame discards frame and restores the table
    send(48'h0A0B0C0D0E0F, 0, 0, 0);
    cyc();
    RST_N = 1'b0;
    cyc();
    chk("M_rst_valid", 64'(DA_VALID), 64'd0);
    chk("M_rst_done",  64'(DA_DONE),  64'd0);
    chk("M_rst_idx",   64'(DA_MATCH_IDX), 64'd0);
    chk("M_rst_acc",   64'(ACCEPT_CNT), 64'd0);
    chk("M_rst_drop",  64'(DROP_CNT), 64'd0);
    RST_N = 1'b1;
    cyc();
    send(48'h000000111111, 0, 0, 0);
    verdict("N", 1, 2'd0, 4'd0);
    cyc();
`ifdef DA_FILTER_STATS_EN
    chk("N_acc", 64'(ACCEPT_CNT), 64'd1);
`else
    chk("N_acc", 64'(ACCEPT_CNT), 64'd0);
`endif
    send(48'h0A0B0C0D0E0F, 0, 0, 0);          // entry 2 cleared by reset
    verdict("O", 0, 2'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
